reaction_stimulus: RTL and testbench
====================================

Name: reaction_stimulus

Overview:
- Stimulus and scoring end of the reaction-time interface.
- After a start request it waits a pseudo-random delay, lights the LED, and pulses go to the measuring timer.
- Detects early (cheat) presses, consumes the timer's result handshake, and keeps the trial count and best valid time.
- Sits between the user controls (start, button) and the reaction timer / display path.

Parameters:
- TW, 12, width of reaction-time values (ms).
- MIN_DELAY_MS, 1000, fixed part of the LED delay.
- RANGE_BITS, 11, random extra delay is 0 to 2^RANGE_BITS-1 ms.
- WATCHDOG_MS, 2500, max ms in LIT without a result before abandoning the trial.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle trial request.
- btn  in  1  synchronized, debounced user button (level).
- tick_ms  in  1  1 ms enable strobe, one clk wide.
- meas_valid  in  1  timer result strobe, one clk wide.
- meas_time  in  TW  measured reaction time, ms.
- meas_slow  in  1  timer saturated (too slow).
- led  out  1  stimulus LED.
- go  out  1  one-cycle pulse to the timer when the LED turns on.
- cheat  out  1  early press flag, sticky until next accepted start.
- busy  out  1  high in any state other than IDLE.
- best_valid  out  1  best_time holds a real result.
- best_time  out  TW  lowest non-slow meas_time since reset.
- trials  out  4  completed trials, saturating at 15.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; led, go, cheat, best_valid = 0; best_time=0; trials=0; delay_cnt=0; wd_cnt=0; lfsr=SEED (16'h0001 if SEED==0).
- Reset has priority over every other input in the same cycle, mid-trial included. The LED drops the next cycle.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances exactly once per accepted start, after its value is sampled. Trial sequence is deterministic from SEED.
- IDLE:
  - start=1 -> ARMED.
  - delay_cnt <= MIN_DELAY_MS + lfsr[RANGE_BITS-1:0], 16-bit unsigned.
  - cheat <= 0.
- start outside IDLE is ignored. btn and meas_valid in IDLE are ignored.
- ARMED:
  - Each tick_ms decrements delay_cnt.
  - On tick_ms with delay_cnt==1 -> LIT. Next cycle led=1 and go=1 for exactly one cycle. wd_cnt <= 0.
  - btn=1 in any ARMED cycle -> cheat <= 1, led stays 0, -> IDLE. trials unchanged, no go.
  - btn and expiry in the same cycle: cheat wins.
- LIT:
  - led=1. Each tick_ms increments wd_cnt.
  - On meas_valid: led <= 0, trials <= sat(trials+1), -> IDLE.
  - If meas_slow=0 and (best_valid=0 or meas_time < best_time): best_time <= meas_time, best_valid <= 1. An equal time does not update.
  - meas_slow=1: trial counted, best unchanged.
  - On tick_ms with wd_cnt==WATCHDOG_MS-1 and no meas_valid: led <= 0, trials incremented, best unchanged, -> IDLE.
  - meas_valid and watchdog expiry in the same cycle: meas_valid wins.
  - btn in LIT is ignored here; the timer handles it.
- busy = (state != IDLE). It is combinational from the state register.
- All other outputs are registered.
- trials at 15 stays at 15.
- Static check: MIN_DELAY_MS + 2^RANGE_BITS - 1 must be < 65536.

Decomposition:
- Shared package reaction_pkg:
  - state enum (IDLE, ARMED, LIT).
  - TW default.
  - MS_TIMEOUT = 2000, the timer's saturation value.
  - LFSR polynomial constant.
- One sub-module: reaction_lfsr16 (clk, rst, adv, seed, q). It is also reusable by the timer bench.

Test Plan:
- Reset, then start with tick_ms every cycle, SEED=16'hACE1 -> delay 1000+0x4E1=2249 ticks. led rises and go pulses exactly once on cycle 2250 after start; busy=1 throughout.
- LIT, meas_valid with meas_time=350, meas_slow=0 -> led=0, trials=1, best_valid=1, best_time=350. Next trial with meas_time=420 -> best stays 350, trials=2.
- ARMED, btn=1 at tick 500 -> cheat=1, led never rises, no go, trials unchanged, back to IDLE. Next start clears cheat.
- LIT, meas_valid with meas_time=2000, meas_slow=1 -> trial counted, best_time unchanged. LIT with no meas_valid for 2500 ticks -> led=0, IDLE, trials+1.
- Corner cycles:
  - btn on the expiry tick -> cheat, no led.
  - meas_valid on the watchdog tick -> result accepted and best updated.
  - start during LIT -> ignored.
- rst asserted mid-LIT -> next cycle all outputs at reset values, LFSR back to SEED. 16 completed trials -> trials holds 15.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time stimulus/timer pair.
package reaction_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StLit
  } state_e;

  localparam int unsigned TW_DEFAULT = 12;
  // Saturation value reported by the reaction timer.
  localparam int unsigned MS_TIMEOUT = 2000;
  // Galois toggle mask for x^16+x^14+x^13+x^11+1 (right-shifting form).
  localparam logic [15:0] LFSR_POLY  = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    lfsr_next = {1'b0, q[15:1]} ^ (q[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_stimulus_if.sv
// User-control and timer-side signals of the stimulus block.
interface reaction_stimulus_if #(
  parameter int unsigned TW = 12
);
  logic          start;
  logic          btn;
  logic          tick_ms;
  logic          meas_valid;
  logic [TW-1:0] meas_time;
  logic          meas_slow;
  logic          led;
  logic          go;
  logic          cheat;
  logic          busy;
  logic          best_valid;
  logic [TW-1:0] best_time;
  logic [3:0]    trials;

  modport master (
    output start, btn, tick_ms, meas_valid, meas_time, meas_slow,
    input  led, go, cheat, busy, best_valid, best_time, trials
  );

  modport slave (
    input  start, btn, tick_ms, meas_valid, meas_time, meas_slow,
    output led, go, cheat, busy, best_valid, best_time, trials
  );
endinterface

// File: rtl/reaction_lfsr16.sv
// 16-bit Galois LFSR that steps once per adv pulse; a zero seed is forced to 1.
module reaction_lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic [15:0] w_seed;

  // The all-zero state is a lock-up state for this LFSR.
  assign w_seed = (seed == 16'h0000) ? 16'h0001 : seed;

  // State register: reload seed on reset, step on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= w_seed;
    end else if (adv) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/reaction_stimulus.sv
// Reaction-test stimulus: random LED delay, cheat detection, result scoring.
module reaction_stimulus
  import reaction_pkg::*;
#(
  parameter int unsigned TW           = TW_DEFAULT,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RANGE_BITS   = 11,
  parameter int unsigned WATCHDOG_MS  = 2500,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input logic                clk,
  input logic                rst,
  reaction_stimulus_if.slave bus
);

  localparam logic [15:0] MinDelay  = 16'(MIN_DELAY_MS);
  localparam logic [15:0] RangeMask = 16'((2 ** RANGE_BITS) - 1);
  localparam logic [15:0] WdLast    = 16'(WATCHDOG_MS - 1);

  if (MIN_DELAY_MS + (2 ** RANGE_BITS) - 1 >= 65536) begin : g_delay_range_chk
    $error("MIN_DELAY_MS + 2^RANGE_BITS - 1 does not fit the 16-bit delay counter");
  end

  state_e        r_state, w_state_nxt;
  logic          r_led, w_led_nxt;
  logic          r_go, w_go_nxt;
  logic          r_cheat, w_cheat_nxt;
  logic          r_best_valid, w_best_valid_nxt;
  logic [TW-1:0] r_best_time, w_best_time_nxt;
  logic [3:0]    r_trials, w_trials_nxt;
  logic [15:0]   r_delay_cnt, w_delay_cnt_nxt;
  logic [15:0]   r_wd_cnt, w_wd_cnt_nxt;
  logic [15:0]   w_lfsr;
  logic          w_lfsr_adv;
  logic [3:0]    w_trials_inc;

  reaction_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (w_lfsr_adv),
    .seed (SEED),
    .q    (w_lfsr)
  );

  assign w_trials_inc = (r_trials == 4'hF) ? r_trials : r_trials + 4'd1;

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_led        <= 1'b0;
      r_go         <= 1'b0;
      r_cheat      <= 1'b0;
      r_best_valid <= 1'b0;
      r_best_time  <= '0;
      r_trials     <= 4'd0;
      r_delay_cnt  <= 16'd0;
      r_wd_cnt     <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_led        <= w_led_nxt;
      r_go         <= w_go_nxt;
      r_cheat      <= w_cheat_nxt;
      r_best_valid <= w_best_valid_nxt;
      r_best_time  <= w_best_time_nxt;
      r_trials     <= w_trials_nxt;
      r_delay_cnt  <= w_delay_cnt_nxt;
      r_wd_cnt     <= w_wd_cnt_nxt;
    end
  end

  // Next-state and next-output logic for the trial sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_led_nxt        = r_led;
    w_go_nxt         = 1'b0;
    w_cheat_nxt      = r_cheat;
    w_best_valid_nxt = r_best_valid;
    w_best_time_nxt  = r_best_time;
    w_trials_nxt     = r_trials;
    w_delay_cnt_nxt  = r_delay_cnt;
    w_wd_cnt_nxt     = r_wd_cnt;
    w_lfsr_adv       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_nxt     = StArmed;
          w_delay_cnt_nxt = MinDelay + (w_lfsr & RangeMask);
          w_cheat_nxt     = 1'b0;
          w_lfsr_adv      = 1'b1;
        end
      end
      StArmed: begin
        // An early press beats a same-cycle delay expiry.
        if (bus.btn) begin
          w_cheat_nxt = 1'b1;
          w_state_nxt = StIdle;
        end else if (bus.tick_ms) begin
          w_delay_cnt_nxt = r_delay_cnt - 16'd1;
          if (r_delay_cnt == 16'd1) begin
            w_state_nxt  = StLit;
            w_led_nxt    = 1'b1;
            w_go_nxt     = 1'b1;
            w_wd_cnt_nxt = 16'd0;
          end
        end
      end
      StLit: begin
        // A result beats a same-cycle watchdog expiry.
        if (bus.meas_valid) begin
          w_led_nxt    = 1'b0;
          w_trials_nxt = w_trials_inc;
          w_state_nxt  = StIdle;
          if (!bus.meas_slow && (!r_best_valid || bus.meas_time < r_best_time)) begin
            w_best_time_nxt  = bus.meas_time;
            w_best_valid_nxt = 1'b1;
          end
        end else if (bus.tick_ms) begin
          w_wd_cnt_nxt = r_wd_cnt + 16'd1;
          if (r_wd_cnt == WdLast) begin
            w_led_nxt    = 1'b0;
            w_trials_nxt = w_trials_inc;
            w_state_nxt  = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign bus.busy       = (r_state != StIdle);
  assign bus.led        = r_led;
  assign bus.go         = r_go;
  assign bus.cheat      = r_cheat;
  assign bus.best_valid = r_best_valid;
  assign bus.best_time  = r_best_time;
  assign bus.trials     = r_trials;

endmodule

// File: tb/tb_reaction_stimulus.sv
// Directed bench for reaction_stimulus: vector table plus corner-case sequences.
module tb_reaction_stimulus;
  import reaction_pkg::*;

  localparam int unsigned TW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   go_count = 0;
  logic [15:0] m_lfsr;

  reaction_stimulus_if #(.TW(TW)) bus ();

  reaction_stimulus #(.TW(TW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count cycles in which go is high.
  always @(negedge clk) begin
    if (bus.go === 1'b1) go_count <= go_count + 1;
  end

  typedef struct {
    int n;
    bit st, bt, tk, mv;
    int mt;
    bit ms;
    bit led, go, ch, busy, bv;
    int btime, tr, gos;
  } vec_t;

  vec_t vecs[22];

  function automatic logic [15:0] model_step(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int led, input int go, input int ch,
                            input int busy, input int bv, input int bt, input int tr);
    check({tag, " led"}, int'(bus.led), led);
    check({tag, " go"}, int'(bus.go), go);
    check({tag, " cheat"}, int'(bus.cheat), ch);
    check({tag, " busy"}, int'(bus.busy), busy);
    check({tag, " best_valid"}, int'(bus.best_valid), bv);
    check({tag, " best_time"}, int'(bus.best_time), bt);
    check({tag, " trials"}, int'(bus.trials), tr);
  endtask

  // Hold inputs for n rising edges, then settle just after the falling edge.
  task automatic step(input int n, input bit st, input bit bt, input bit tk, input bit mv,
                      input int mt, input bit ms);
    bus.start      = st;
    bus.btn        = bt;
    bus.tick_ms    = tk;
    bus.meas_valid = mv;
    bus.meas_time  = 12'(mt);
    bus.meas_slow  = ms;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic start_trial(output int d);
    d      = 1000 + int'(m_lfsr[10:0]);
    m_lfsr = model_step(m_lfsr);
    step(1, 1, 0, 1, 0, 0, 0);
  endtask

  initial begin
    int d;
    int g0;
    int best;

    //            n    st bt tk mv mt   ms  led go ch busy bv best tr gos
    vecs[0]  = '{1,    1, 0, 1, 0, 0,   0,  0, 0, 0, 1,  0, 0,   0, 0};
    vecs[1]  = '{2248, 0, 0, 1, 0, 0,   0,  0, 0, 0, 1,  0, 0,   0, 0};
    vecs[2]  = '{1,    0, 0, 1, 0, 0,   0,  1, 1, 0, 1,  0, 0,   0, 1};
    vecs[3]  = '{1,    0, 0, 1, 0, 0,   0,  1, 0, 0, 1,  0, 0,   0, 1};
    vecs[4]  = '{1,    0, 0, 0, 1, 350, 0,  0, 0, 0, 0,  1, 350, 1, 1};
    vecs[5]  = '{1,    1, 0, 1, 0, 0,   0,  0, 0, 0, 1,  1, 350, 1, 1};
    vecs[6]  = '{1623, 0, 0, 1, 0, 0,   0,  0, 0, 0, 1,  1, 350, 1, 1};
    vecs[7]  = '{1,    0, 0, 1, 0, 0,   0,  1, 1, 0, 1,  1, 350, 1, 2};
    vecs[8]  = '{1,    0, 0, 1, 1, 420, 0,  0, 0, 0, 0,  1, 350, 2, 2};
    vecs[9]  = '{1,    1, 0, 1, 0, 0,   0,  0, 0, 0, 1,  1, 350, 2, 2};
    vecs[10] = '{499,  0, 0, 1, 0, 0,   0,  0, 0, 0, 1,  1, 350, 2, 2};
    vecs[11] = '{1,    0, 1, 1, 0, 0,   0,  0, 0, 1, 0,  1, 350, 2, 2};
    vecs[12] = '{10,   0, 1, 1, 1, 5,   0,  0, 0, 1, 0,  1, 350, 2, 2};
    vecs[13] = '{1,    1, 0, 1, 0, 0,   0,  0, 0, 0, 1,  1, 350, 2, 2};
    vecs[14] = '{1155, 0, 0, 1, 0, 0,   0,  0, 0, 0, 1,  1, 350, 2, 2};
    vecs[15] = '{1,    0, 0, 1, 0, 0,   0,  1, 1, 0, 1,  1, 350, 2, 3};
    vecs[16] = '{1,    0, 0, 0, 1, 2000, 1, 0, 0, 0, 0,  1, 350, 3, 3};
    vecs[17] = '{1,    1, 0, 1, 0, 0,   0,  0, 0, 0, 1,  1, 350, 3, 3};
    vecs[18] = '{2101, 0, 0, 1, 0, 0,   0,  0, 0, 0, 1,  1, 350, 3, 3};
    vecs[19] = '{1,    0, 0, 1, 0, 0,   0,  1, 1, 0, 1,  1, 350, 3, 4};
    vecs[20] = '{2499, 1, 1, 1, 0, 0,   0,  1, 0, 0, 1,  1, 350, 3, 4};
    vecs[21] = '{1,    0, 0, 1, 0, 0,   0,  0, 0, 0, 0,  1, 350, 4, 4};

    // Reset wins over every other input.
    rst = 1'b1;
    step(3, 1, 1, 1, 1, 77, 0);
    rst = 1'b0;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    check("reset go_count", go_count, 0);

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].n, vecs[i].st, vecs[i].bt, vecs[i].tk, vecs[i].mv, vecs[i].mt, vecs[i].ms);
      check_outs($sformatf("vec%0d", i), vecs[i].led, vecs[i].go, vecs[i].ch, vecs[i].busy,
                 vecs[i].bv, vecs[i].btime, vecs[i].tr);
      check($sformatf("vec%0d go_count", i), go_count, vecs[i].gos);
    end

    // The LFSR has stepped once per accepted start (five so far).
    m_lfsr = 16'hACE1;
    repeat (5) m_lfsr = model_step(m_lfsr);

    // Button on the expiry tick: cheat, no LED, no go.
    g0 = go_count;
    start_trial(d);
    step(d - 1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0);
    check_outs("btn_on_expiry", 0, 0, 1, 0, 1, 350, 4);
    step(3, 0, 0, 1, 0, 0, 0);
    check("btn_on_expiry led_later", int'(bus.led), 0);
    check("btn_on_expiry go_count", go_count - g0, 0);

    // Result on the watchdog tick is accepted and updates best.
    start_trial(d);
    step(d, 0, 0, 1, 0, 0, 0);
    check("wd_corner lit", int'(bus.led), 1);
    step(2499, 0, 0, 1, 0, 0, 0);
    check("wd_corner still_lit", int'(bus.led), 1);
    step(1, 0, 0, 1, 1, 200, 0);
    check_outs("wd_corner", 0, 0, 0, 0, 1, 200, 5);

    // Reset in the middle of LIT.
    start_trial(d);
    step(d, 0, 0, 1, 0, 0, 0);
    check("rst_mid lit", int'(bus.led), 1);
    rst = 1'b1;
    step(1, 0, 0, 1, 0, 0, 0);
    rst = 1'b0;
    check_outs("rst_mid", 0, 0, 0, 0, 0, 0, 0);

    // LFSR is back at SEED: first delay is again 2249.
    m_lfsr = 16'hACE1;
    g0 = go_count;
    start_trial(d);
    check("seed_delay model", d, 2249);
    step(2248, 0, 0, 1, 0, 0, 0);
    check("seed_delay led_before", int'(bus.led), 0);
    step(1, 0, 0, 1, 0, 0, 0);
    check("seed_delay led", int'(bus.led), 1);
    check("seed_delay go", int'(bus.go), 1);
    check("seed_delay go_count", go_count - g0, 1);

    // Sixteen completed trials saturate the counter at 15; slow results never count as best.
    best = 900;
    step(1, 0, 0, 0, 1, 900, 0);
    check("sat trials1", int'(bus.trials), 1);
    for (int i = 2; i <= 16; i++) begin
      start_trial(d);
      step(d, 0, 0, 1, 0, 0, 0);
      if (i == 8) begin
        step(1, 0, 0, 0, 1, 10, 1);
      end else begin
        step(1, 0, 0, 0, 1, 900 - i, 0);
        if (900 - i < best) best = 900 - i;
      end
      check($sformatf("sat trials%0d", i), int'(bus.trials), (i > 15) ? 15 : i);
    end
    check("sat best_time", int'(bus.best_time), best);
    check("sat best_valid", int'(bus.best_valid), 1);
    check("sat busy", int'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
